// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
// Shared definitions for the instruction fetch stage.
//   fetch_state_e         : fetch FSM states (FETCH, WAIT, HALTED)
//   DEFAULT_RESET_VECTOR  : first instruction address after reset
//   DEFAULT_HALT_ADDRESS  : PC value at which fetch stops for good
//   word_align()          : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDRESS = 32'h0000_0000;

    // Instruction memory is word addressed; the two low bits are never set.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for a fetched word that completed while the
// downstream stage was stalled. Only built when IFETCH_SKID_BUFFER_EN is
// defined; the default build contains no skid buffer at all.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; empties the buffer
//   capture_i  in   load data_i and mark the buffer full
//   data_i     in   fetched word to hold
//   release_i  in   buffered word consumed this cycle; mark empty
//   full_o     out  buffer holds a word
//   data_o     out  buffered word
// -----------------------------------------------------------------------------
`ifdef IFETCH_SKID_BUFFER_EN
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_i,
    input  logic [31:0] data_i,
    input  logic        release_i,
    output logic        full_o,
    output logic [31:0] data_o
);

    logic        full_q;
    logic [31:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (capture_i) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end else if (release_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule
`endif

// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
// Program counter and instruction fetch for a MIPS-style pipeline with a
// branch delay slot. Issues word reads, holds them through waitrequest,
// delivers completed words to the Fetch/Decode register with zero added
// latency, and stops fetching for good when the PC reaches HALT_ADDRESS.
//
// Optional feature macro: IFETCH_SKID_BUFFER_EN
//   defined   : a word completing under stall is held in fetch_skid_buffer
//               and delivered in the first unstalled cycle (no re-read).
//   undefined : a word completing under stall is dropped and re-read.
//
// Parameters:
//   RESET_VECTOR  first fetch address after reset
//   HALT_ADDRESS  PC value that halts fetch
// Ports:
//   clk                              in   rising-edge clock
//   reset                            in   asynchronous, active-high
//   stall                            in   downstream cannot accept an instruction
//   redirect_valid                   in   branch/jump resolved in decode (pulse)
//   redirect_target                  in   target PC, valid with redirect_valid
//   instr_address                    out  word address of the current PC
//   instr_read                       out  memory read request
//   instr_waitrequest                in   memory not ready, request held
//   instr_readdata                   in   fetched word
//   instruction_fetch                out  instruction to Fetch/Decode
//   instr_valid_fetch                out  instruction_fetch valid this cycle
//   program_counter_plus_four_fetch  out  instr_address + 4
//   HALT_fetch                       out  fetch halted (sticky until reset)
// -----------------------------------------------------------------------------
module pc_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDRESS = DEFAULT_HALT_ADDRESS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instruction_fetch,
    output logic        instr_valid_fetch,
    output logic [31:0] program_counter_plus_four_fetch,
    output logic        HALT_fetch
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_tgt_q, redir_tgt_d;

    logic         pc_is_halt;
    logic [31:0]  pc_plus_four;
    logic         read_req;
    logic         mem_done;
    logic         deliver_mem;
    logic         deliver_skid;
    logic         advance;
    logic [31:0]  next_pc;

    assign pc_is_halt   = (pc_q == HALT_ADDRESS);
    assign pc_plus_four = pc_q + 32'd4;   // wraps modulo 2^32

`ifdef IFETCH_SKID_BUFFER_EN
    logic        skid_full;
    logic [31:0] skid_data;
    logic        skid_capture;
    logic        skid_release;

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .reset     (reset),
        .capture_i (skid_capture),
        .data_i    (instr_readdata),
        .release_i (skid_release),
        .full_o    (skid_full),
        .data_o    (skid_data)
    );
`endif

    // Read request, completion and delivery.
    always_comb begin
        read_req     = 1'b0;
        deliver_skid = 1'b0;
        unique case (state_q)
            FETCH:   read_req = !stall && !pc_is_halt;
            WAIT:    read_req = 1'b1;   // a started read is never withdrawn
            default: read_req = 1'b0;
        endcase
`ifdef IFETCH_SKID_BUFFER_EN
        // While a word sits in the buffer the PC still names it, so no new
        // read may start until it has been handed over.
        if (skid_full) begin
            read_req = 1'b0;
        end
`endif
        if (reset) begin
            read_req = 1'b0;
        end

        mem_done    = read_req && !instr_waitrequest;
        deliver_mem = mem_done && !stall;

`ifdef IFETCH_SKID_BUFFER_EN
        deliver_skid = skid_full && !stall;
        skid_capture = mem_done && stall;
        skid_release = deliver_skid;
`endif
    end

    assign advance = deliver_mem || deliver_skid;

    // The redirect names the instruction after the one at the current PC:
    // the current PC is the delay slot of the branch sitting in decode, so it
    // is always delivered first. A redirect arriving with the delivery wins
    // over an older pending one.
    always_comb begin
        if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (redir_pend_q) begin
            next_pc = redir_tgt_q;
        end else begin
            next_pc = pc_plus_four;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;

        if (advance) begin
            pc_d         = word_align(next_pc);
            redir_pend_d = 1'b0;
        end else if (redirect_valid && (state_q != HALTED)) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = redirect_target;
        end

        unique case (state_q)
            FETCH: begin
                if (pc_is_halt) begin
                    state_d = HALTED;
                end else if (read_req && instr_waitrequest) begin
                    state_d = WAIT;
                end
            end
            // Leaving WAIT without a delivery (stalled completion) returns to
            // FETCH with the PC unchanged, so the same word is fetched again
            // unless the skid buffer caught it.
            WAIT: begin
                if (!instr_waitrequest) begin
                    state_d = FETCH;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= word_align(RESET_VECTOR);
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    assign instr_address                   = pc_q;
    assign instr_read                      = read_req;
    assign instr_valid_fetch               = advance;
    assign program_counter_plus_four_fetch = pc_plus_four;
    assign HALT_fetch                      = (state_q == HALTED);

`ifdef IFETCH_SKID_BUFFER_EN
    assign instruction_fetch = deliver_skid ? skid_data : instr_readdata;
`else
    assign instruction_fetch = instr_readdata;
`endif

endmodule
